// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART state encoding, parameter legality limits and a
//               counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        START  = 5'b00010,
        DATA   = 5'b00100,
        PARITY = 5'b01000,
        STOP   = 5'b10000
    } state_t;

    localparam int CLKS_PER_BIT_MIN = 1;
    localparam int CLKS_PER_BIT_MAX = 65535;
    localparam int DATA_BITS_MIN    = 5;
    localparam int DATA_BITS_MAX    = 9;
    localparam int STOP_BITS_MIN    = 1;
    localparam int STOP_BITS_MAX    = 2;

    // Width of a down-counter holding values 0..n-1, never narrower than 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
// Module      : uart_baud_tick
// Description : Per-bit down-counter; tick marks the last cycle of a bit period
//               and the counter reloads on tick or on an explicit reload.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic reload,
    output logic tick
);

    localparam int                c_cnt_w  = cnt_width(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_reload = c_cnt_w'(CLKS_PER_BIT - 1);

    logic [c_cnt_w-1:0] cnt_q;
    logic [c_cnt_w-1:0] cnt_d;

    assign tick = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q - c_cnt_w'(1);
        if (reload || tick) begin
            cnt_d = c_reload;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_cfg.sv
// ============================================================================
// Module      : uart_tx_cfg
// Description : Configurable UART transmitter (start, LSB-first data, optional
//               parity, 1-2 stop bits). Parity is built only when the macro
//               UART_TX_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 2,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 send,
    input  logic [DATA_BITS-1:0] data,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int                 c_bit_w     = cnt_width(DATA_BITS);
    localparam logic [c_bit_w-1:0] c_last_data = c_bit_w'(DATA_BITS - 1);
    localparam logic [c_bit_w-1:0] c_last_stop = c_bit_w'(STOP_BITS - 1);

    generate
        if (CLKS_PER_BIT < CLKS_PER_BIT_MIN || CLKS_PER_BIT > CLKS_PER_BIT_MAX ||
            DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX ||
            STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX ||
            PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
            $error("uart_tx_cfg: parameter out of legal range");
        end
    endgenerate

    state_t               state_q, state_d;
    state_t               state;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [c_bit_w-1:0]   bit_cnt_q, bit_cnt_d;
    logic                 tick;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    assign state = state_q;
    assign busy  = (state != IDLE);

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk    (clk),
        .rst    (rst),
        .reload (state_d != state),
        .tick   (tick)
    );

    always_comb begin
        state_d   = state;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        tx        = 1'b1;
        tx_done   = 1'b0;
        case (state)
            IDLE: begin
                if (send) begin
                    shift_d   = data;
                    bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                    parity_d  = (^data) ^ 1'(PARITY_ODD);
`endif
                    state_d   = START;
                end
            end
            START: begin
                tx = 1'b0;
                if (tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                tx = shift_q[0];
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == c_last_data) begin
                        bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + c_bit_w'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx = parity_q;
                if (tick) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (bit_cnt_q == c_last_stop) begin
                        tx_done = 1'b1;
                        state_d = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + c_bit_w'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
// ============================================================================
// Module      : tb_uart_tx_cfg
// Description : Directed bench for uart_tx_cfg across several parameter sets.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_tx_cfg;

`ifdef UART_TX_PARITY_EN
    localparam int c_p = 1;
`else
    localparam int c_p = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // CLKS_PER_BIT=2, DATA_BITS=8, STOP_BITS=1, even parity
    logic       send_a = 1'b0;
    logic [7:0] data_a = 8'h00;
    logic       tx_a, busy_a, done_a;
    // same, odd parity
    logic       send_o = 1'b0;
    logic [7:0] data_o = 8'h00;
    logic       tx_o, busy_o, done_o;
    // DATA_BITS=5, STOP_BITS=2
    logic       send_s = 1'b0;
    logic [4:0] data_s = 5'h00;
    logic       tx_s, busy_s, done_s;
    // CLKS_PER_BIT=1
    logic       send_c = 1'b0;
    logic [7:0] data_c = 8'h00;
    logic       tx_c, busy_c, done_c;

    uart_tx_cfg #(.CLKS_PER_BIT(2), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut (
        .clk(clk), .rst(rst), .send(send_a), .data(data_a),
        .tx(tx_a), .busy(busy_a), .tx_done(done_a));

    uart_tx_cfg #(.CLKS_PER_BIT(2), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1)) dut_odd (
        .clk(clk), .rst(rst), .send(send_o), .data(data_o),
        .tx(tx_o), .busy(busy_o), .tx_done(done_o));

    uart_tx_cfg #(.CLKS_PER_BIT(2), .DATA_BITS(5), .STOP_BITS(2), .PARITY_ODD(0)) dut_s2 (
        .clk(clk), .rst(rst), .send(send_s), .data(data_s),
        .tx(tx_s), .busy(busy_s), .tx_done(done_s));

    uart_tx_cfg #(.CLKS_PER_BIT(1), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut_c1 (
        .clk(clk), .rst(rst), .send(send_c), .data(data_c),
        .tx(tx_c), .busy(busy_c), .tx_done(done_c));

    // Expected line levels per bit period, first transmitted bit leftmost.
`ifdef UART_TX_PARITY_EN
    localparam logic [0:10] c_exp_48_even = 11'b00001001001;
    localparam logic [0:10] c_exp_48_odd  = 11'b00001001011;
    localparam logic [0:10] c_exp_a5      = 11'b01010010101;
    localparam logic [0:10] c_exp_1f_s2   = 11'b01111111100;
    localparam logic [0:10] c_exp_01_c1   = 11'b01000000011;
`else
    localparam logic [0:10] c_exp_48_even = 11'b00001001010;
    localparam logic [0:10] c_exp_48_odd  = 11'b00001001010;
    localparam logic [0:10] c_exp_a5      = 11'b01010010110;
    localparam logic [0:10] c_exp_1f_s2   = 11'b01111111000;
    localparam logic [0:10] c_exp_01_c1   = 11'b01000000010;
`endif
    localparam int c_len8 = 10 + c_p;
    localparam int c_len5 = 8 + c_p;

    task automatic test_reset();
        @(negedge clk);
        n_vec++; if (tx_a !== 1'b1)   begin n_err++; $display("FAIL reset tx: got %b want 1", tx_a); end
        n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b want 0", busy_a); end
        n_vec++; if (done_a !== 1'b0) begin n_err++; $display("FAIL reset tx_done: got %b want 0", done_a); end
        n_vec++; if (dut.state !== 5'b00001) begin n_err++; $display("FAIL reset state: got %b want 00001", dut.state); end
        rst = 1'b0;
    endtask

    task automatic test_frame_48();
        logic exp_done;
        @(negedge clk); send_a = 1'b1; data_a = 8'h48;
        @(negedge clk); send_a = 1'b0; data_a = 8'h00;
        for (int c = 1; c <= 2 * c_len8; c++) begin
            exp_done = (c == 2 * c_len8);
            n_vec++; if (tx_a !== c_exp_48_even[(c-1)/2]) begin n_err++; $display("FAIL frame48 tx c%0d: got %b want %b", c, tx_a, c_exp_48_even[(c-1)/2]); end
            n_vec++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL frame48 busy c%0d: got %b want 1", c, busy_a); end
            n_vec++; if (done_a !== exp_done) begin n_err++; $display("FAIL frame48 tx_done c%0d: got %b want %b", c, done_a, exp_done); end
            @(negedge clk);
        end
        n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL frame48 busy after: got %b want 0", busy_a); end
        n_vec++; if (done_a !== 1'b0) begin n_err++; $display("FAIL frame48 tx_done after: got %b want 0", done_a); end
    endtask

    task automatic test_parity_odd();
        logic exp_done;
        @(negedge clk); send_o = 1'b1; data_o = 8'h48;
        @(negedge clk); send_o = 1'b0;
        for (int c = 1; c <= 2 * c_len8; c++) begin
            exp_done = (c == 2 * c_len8);
            n_vec++; if (tx_o !== c_exp_48_odd[(c-1)/2]) begin n_err++; $display("FAIL odd tx c%0d: got %b want %b", c, tx_o, c_exp_48_odd[(c-1)/2]); end
            n_vec++; if (done_o !== exp_done) begin n_err++; $display("FAIL odd tx_done c%0d: got %b want %b", c, done_o, exp_done); end
            @(negedge clk);
        end
        n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL odd busy after: got %b want 0", busy_o); end
    endtask

    task automatic test_stop2();
        logic exp_done;
        @(negedge clk); send_s = 1'b1; data_s = 5'h1F;
        @(negedge clk); send_s = 1'b0;
        for (int c = 1; c <= 2 * c_len5; c++) begin
            exp_done = (c == 2 * c_len5);
            n_vec++; if (tx_s !== c_exp_1f_s2[(c-1)/2]) begin n_err++; $display("FAIL stop2 tx c%0d: got %b want %b", c, tx_s, c_exp_1f_s2[(c-1)/2]); end
            n_vec++; if (busy_s !== 1'b1) begin n_err++; $display("FAIL stop2 busy c%0d: got %b want 1", c, busy_s); end
            n_vec++; if (done_s !== exp_done) begin n_err++; $display("FAIL stop2 tx_done c%0d: got %b want %b", c, done_s, exp_done); end
            @(negedge clk);
        end
        n_vec++; if (busy_s !== 1'b0) begin n_err++; $display("FAIL stop2 busy after: got %b want 0", busy_s); end
        n_vec++; if (tx_s !== 1'b1) begin n_err++; $display("FAIL stop2 tx after: got %b want 1", tx_s); end
    endtask

    task automatic test_clk1();
        logic exp_done;
        @(negedge clk); send_c = 1'b1; data_c = 8'h01;
        @(negedge clk); send_c = 1'b0;
        for (int c = 1; c <= c_len8; c++) begin
            exp_done = (c == c_len8);
            n_vec++; if (tx_c !== c_exp_01_c1[c-1]) begin n_err++; $display("FAIL clk1 tx c%0d: got %b want %b", c, tx_c, c_exp_01_c1[c-1]); end
            n_vec++; if (done_c !== exp_done) begin n_err++; $display("FAIL clk1 tx_done c%0d: got %b want %b", c, done_c, exp_done); end
            @(negedge clk);
        end
        n_vec++; if (busy_c !== 1'b0) begin n_err++; $display("FAIL clk1 busy after: got %b want 0", busy_c); end
    endtask

    task automatic test_back_to_back();
        logic exp_done;
        @(negedge clk); send_a = 1'b1; data_a = 8'h48;
        @(negedge clk);
        for (int c = 1; c <= 2 * c_len8; c++) begin
            if (c == 5) data_a = 8'hA5;
            exp_done = (c == 2 * c_len8);
            n_vec++; if (tx_a !== c_exp_48_even[(c-1)/2]) begin n_err++; $display("FAIL b2b first tx c%0d: got %b want %b", c, tx_a, c_exp_48_even[(c-1)/2]); end
            n_vec++; if (done_a !== exp_done) begin n_err++; $display("FAIL b2b first tx_done c%0d: got %b want %b", c, done_a, exp_done); end
            @(negedge clk);
        end
        n_vec++; if (dut.state !== 5'b00001) begin n_err++; $display("FAIL b2b gap state: got %b want 00001", dut.state); end
        n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL b2b gap busy: got %b want 0", busy_a); end
        @(negedge clk);
        for (int c = 1; c <= 2 * c_len8; c++) begin
            if (c == 3) send_a = 1'b0;
            exp_done = (c == 2 * c_len8);
            n_vec++; if (tx_a !== c_exp_a5[(c-1)/2]) begin n_err++; $display("FAIL b2b second tx c%0d: got %b want %b", c, tx_a, c_exp_a5[(c-1)/2]); end
            n_vec++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL b2b second busy c%0d: got %b want 1", c, busy_a); end
            n_vec++; if (done_a !== exp_done) begin n_err++; $display("FAIL b2b second tx_done c%0d: got %b want %b", c, done_a, exp_done); end
            @(negedge clk);
        end
        n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL b2b busy after: got %b want 0", busy_a); end
    endtask

    task automatic test_midframe_reset();
        logic exp_done;
        @(negedge clk); send_a = 1'b1; data_a = 8'h48;
        @(negedge clk); send_a = 1'b0;
        repeat (8) @(negedge clk);
        // first cycle of data bit 3, which is a 1 for 8'h48
        n_vec++; if (dut.state !== 5'b00100) begin n_err++; $display("FAIL mid state before rst: got %b want 00100", dut.state); end
        n_vec++; if (tx_a !== 1'b1) begin n_err++; $display("FAIL mid tx bit3: got %b want 1", tx_a); end
        rst = 1'b1;
        #1;
        n_vec++; if (tx_a !== 1'b1)   begin n_err++; $display("FAIL mid rst tx: got %b want 1", tx_a); end
        n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL mid rst busy: got %b want 0", busy_a); end
        n_vec++; if (done_a !== 1'b0) begin n_err++; $display("FAIL mid rst tx_done: got %b want 0", done_a); end
        n_vec++; if (dut.state !== 5'b00001) begin n_err++; $display("FAIL mid rst state: got %b want 00001", dut.state); end
        @(negedge clk); rst = 1'b0; send_a = 1'b1; data_a = 8'hA5;
        @(negedge clk); send_a = 1'b0;
        for (int c = 1; c <= 2 * c_len8; c++) begin
            exp_done = (c == 2 * c_len8);
            n_vec++; if (tx_a !== c_exp_a5[(c-1)/2]) begin n_err++; $display("FAIL post-rst tx c%0d: got %b want %b", c, tx_a, c_exp_a5[(c-1)/2]); end
            n_vec++; if (done_a !== exp_done) begin n_err++; $display("FAIL post-rst tx_done c%0d: got %b want %b", c, done_a, exp_done); end
            @(negedge clk);
        end
        n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL post-rst busy after: got %b want 0", busy_a); end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_frame_48();
        test_parity_odd();
        test_stop2();
        test_clk1();
        test_back_to_back();
        test_midframe_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 2: clk cycles per serial bit, legal range 1..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8: payload width, legal range 5..9.
REQ-003 SHALL have parameter STOP_BITS, default 1: stop bit count, legal values 1 or 2.
REQ-004 SHALL have parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity; effective only with UART_TX_PARITY_EN.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port send, input, 1 bit: frame request, sampled every cycle.
REQ-008 SHALL have port data, input, DATA_BITS bits: payload, captured on acceptance.
REQ-009 SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-010 SHALL have port busy, output, 1 bit: high from acceptance through the last stop-bit cycle.
REQ-011 SHALL have port tx_done, output, 1 bit: one-cycle pulse at frame end.

Function
REQ-012 SHALL use the one-hot states IDLE, START, DATA, PARITY, STOP.
REQ-013 SHALL accept a frame when send=1 in IDLE: capture data, and on the next edge enter START with tx=0 and busy=1.
REQ-014 SHALL ignore send while busy=1; no queuing.
REQ-015 SHALL hold each bit on tx for exactly CLKS_PER_BIT cycles, timed by a bit-tick counter that reloads on every state change.
REQ-016 SHALL send DATA bits LSB first, advancing after each bit period until DATA_BITS bits are sent.
REQ-017 SHALL go from DATA to PARITY when parity is compiled in, otherwise to STOP.
REQ-018 SHALL drive in PARITY the XOR of the captured bits, inverted when PARITY_ODD=1.
REQ-019 SHALL drive tx=1 in STOP for STOP_BITS*CLKS_PER_BIT cycles.
REQ-020 SHALL, on the last STOP cycle, pulse tx_done for one cycle, deassert busy, and return to IDLE.
REQ-021 SHALL accept send=1 in the IDLE cycle after tx_done, allowing back-to-back frames with no extra idle time.
REQ-022 SHALL set frame length to 1+DATA_BITS+P+STOP_BITS bit periods (P = 1 with parity, else 0); a frame accepted at edge N ends with tx_done high during cycle N+length*CLKS_PER_BIT.
REQ-023 SHALL hold tx=0 for a full period before any data bit when CLKS_PER_BIT=1.

Reset
REQ-024 SHALL, on rst asserted at any time including mid-frame, force IDLE, tx=1, busy=0, tx_done=0, and clear counters and shift register asynchronously.
REQ-025 SHALL, after rst deasserts, accept send on the first rising edge.

Configuration
REQ-026 SHALL compile in the PARITY state, the parity bit and PARITY_ODD when macro UART_TX_PARITY_EN is defined.
REQ-027 SHALL, without UART_TX_PARITY_EN, contain no parity logic: DATA goes directly to STOP and PARITY_ODD is ignored.

Structure
REQ-028 SHALL take from shared package uart_pkg: the state typedef with one-hot encodings IDLE=5'b00001, START=5'b00010, DATA=5'b00100, PARITY=5'b01000, STOP=5'b10000, and the parameter legality constants.
REQ-029 SHALL instantiate one sub-module, uart_baud_tick, which provides the per-bit tick counter with a reload input.
REQ-030 SHALL expose internal signal state for bench inspection.

Verification
REQ-031 SHALL test CLKS_PER_BIT=2, DATA_BITS=8, no parity, data=8'h48: tx = 0, 0,0,0,1,0,0,1,0, 1 with each bit 2 cycles; tx_done high exactly 20 cycles after acceptance.
REQ-032 SHALL test UART_TX_PARITY_EN with data=8'h48: parity bit 0 when PARITY_ODD=0 and 1 when PARITY_ODD=1; frame length 11 bits.
REQ-033 SHALL test STOP_BITS=2, DATA_BITS=5, data=5'h1F: tx high for 4 cycles after the data bits, then tx_done, and busy low the cycle after.
REQ-034 SHALL test send held high through a frame and a new data value mid-frame: the frame still carries the original byte, and a second frame starts in the IDLE cycle after tx_done.
REQ-035 SHALL test rst pulsed during data bit 3: tx=1, busy=0, state=IDLE immediately, and a fresh frame with data=8'hA5 is sent correctly afterwards.
